// File: rtl/tns_encoder_param_if.sv
// Handshake bundle for the TNS encoder: input data stream, history clear,
// and the registered codeword stream with its overflow flag.
interface tns_encoder_param_if #(
    parameter int NG = 11,
    parameter int DW = 24
);
    logic [DW-1:0]   datain;
    logic            in_valid;
    logic            in_ready;
    logic            hist_clr;
    logic [3*NG-1:0] codeout;
    logic            out_valid;
    logic            out_ready;
    logic            out_ovf;

    modport master (
        output datain, in_valid, hist_clr, out_ready,
        input  in_ready, codeout, out_valid, out_ovf
    );

    modport slave (
        input  datain, in_valid, hist_clr, out_ready,
        output in_ready, codeout, out_valid, out_ovf
    );
endinterface

// File: rtl/tns_encoder_param.sv
// Three-wire-per-group encoder: greedy MSB-first decomposition of datain against
// per-group weights, with a history bit resolving each group's ambiguous a-range.
module tns_encoder_param #(
    parameter int NG = 11,
    parameter int DW = 24,
    parameter logic [3*NG*DW-1:0] WEIGHTS = {
        24'd9765625, 24'd9765625, 24'd9765625,
        24'd3906250, 24'd1953125, 24'd1953125,
        24'd781250,  24'd390625,  24'd390625,
        24'd156250,  24'd78125,   24'd78125,
        24'd31250,   24'd15625,   24'd15625,
        24'd6250,    24'd3125,    24'd3125,
        24'd1250,    24'd625,     24'd625,
        24'd250,     24'd125,     24'd125,
        24'd50,      24'd25,      24'd25,
        24'd10,      24'd5,       24'd5,
        24'd2,       24'd1,       24'd1
    },
    parameter longint unsigned CAP = 64'd1 << DW
) (
    input logic                clock,
    input logic                rst_n,
    tns_encoder_param_if.slave bus
);
    localparam int CW = 3 * NG;

    logic [NG-1:0][DW-1:0] rem;
    logic [NG-1:0]         a_vec;
    logic [NG-1:0]         hist;
    logic [CW-1:0]         code_c;
    logic [CW-1:0]         code_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  in_range;
    logic                  xfer;

    assign rem[NG-1] = bus.datain;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        localparam logic [DW-1:0] WA = WEIGHTS[(3*g+2)*DW +: DW];
        localparam logic [DW-1:0] WB = WEIGHTS[(3*g+1)*DW +: DW];
        localparam logic [DW-1:0] WC = WEIGHTS[(3*g)*DW +: DW];
        // Upper bound of the ambiguous a-range, one bit wider so it cannot wrap.
        localparam logic [DW:0]   AC = {1'b0, WA} + {1'b0, WC};

        logic          a;
        logic          b;
        logic          c;
        logic [DW-1:0] r1;

        assign a  = (rem[g] < WA) ? 1'b0 :
                    ({1'b0, rem[g]} >= AC) ? 1'b1 : hist[g];
        assign r1 = a ? rem[g] - WA : rem[g];
        assign b  = (r1 >= WB);

        if (g == 0) begin : g_lsb
            // Only bit 0 of (r1 - WB) is needed, which is r1[0] ^ WB[0].
            assign c = r1[0] ^ (b & WB[0]);
        end else begin : g_mid
            logic [DW-1:0] r2;
            assign r2         = b ? r1 - WB : r1;
            assign c          = (r2 >= WC);
            assign rem[g-1]   = c ? r2 - WC : r2;
        end

        assign code_c[3*g +: 3] = {a, b, c};
        assign a_vec[g]         = a;
    end

    assign in_range      = (64'(bus.datain) < CAP);
    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign xfer          = bus.in_valid && bus.in_ready;
    assign bus.codeout   = code_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ovf   = ovf_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            hist    <= '0;
        end else begin
            if (xfer) begin
                code_q  <= in_range ? code_c : '0;
                ovf_q   <= !in_range;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            // Clear wins; the codeword above already used the pre-clear history.
            if (bus.hist_clr)
                hist <= '0;
            else if (xfer && in_range)
                hist <= a_vec;
        end
    end
endmodule

// File: tb/tb_tns_encoder_param.sv
// Directed and randomized checks of tns_encoder_param in the NG=2, DW=5, CAP=16
// configuration against an arithmetic reference encoder.
module tb_tns_encoder_param;
    localparam int NG  = 2;
    localparam int DW  = 5;
    localparam int CAP = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    int WA[2] = '{2, 8};
    int WB[2] = '{1, 4};
    int WC[2] = '{1, 3};

    // Reference model state
    int   m_code;
    bit   m_valid;
    bit   m_ovf;
    int   m_hist;

    tns_encoder_param_if #(.NG(NG), .DW(DW)) bus ();

    tns_encoder_param #(
        .NG(NG),
        .DW(DW),
        .WEIGHTS({5'd8, 5'd4, 5'd3, 5'd2, 5'd1, 5'd1}),
        .CAP(64'd16)
    ) dut (
        .clock(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int enc(input int v, input int hmask, output int amask);
        int r;
        int code;
        r     = v;
        code  = 0;
        amask = 0;
        for (int g = NG - 1; g >= 0; g--) begin
            int a, b, c;
            if (r < WA[g])                a = 0;
            else if (r >= WA[g] + WC[g])  a = 1;
            else                          a = (hmask >> g) & 1;
            if (a != 0) r -= WA[g];
            b = (r >= WB[g]) ? 1 : 0;
            if (b != 0) r -= WB[g];
            if (g > 0) begin
                c = (r >= WC[g]) ? 1 : 0;
                if (c != 0) r -= WC[g];
            end else begin
                c = r & 1;
            end
            code  |= (a * 4 + b * 2 + c) << (3 * g);
            amask |= a << g;
        end
        return code;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.datain    = '0;
        bus.in_valid  = 1'b0;
        bus.hist_clr  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        m_code  = 0;
        m_valid = 0;
        m_ovf   = 0;
        m_hist  = 0;
    endtask

    task automatic xfer(input int v, input int ec, input int eo, input string tag);
        bus.datain   = 5'(v);
        bus.in_valid = 1'b1;
        step();
        chk({tag, "_code"}, 32'(bus.codeout), 32'(ec));
        chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
        chk({tag, "_ovf"},  32'(bus.out_ovf), 32'(eo));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_code",  32'(bus.codeout), 32'd0);
        chk("rst_vld",   32'(bus.out_valid), 32'd0);
        chk("rst_ovf",   32'(bus.out_ovf), 32'd0);
        chk("rst_rdy",   32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_code", 32'(bus.codeout), 32'd0);
        chk("idle_vld",  32'(bus.out_valid), 32'd0);
        chk("idle_ovf",  32'(bus.out_ovf), 32'd0);
        chk("idle_rdy",  32'(bus.in_ready), 32'd1);

        // Single value
        xfer(5, 6'b010010, 0, "d5");
        bus.in_valid = 1'b0;

        // Back-to-back with history effect, then drain
        do_reset();
        xfer(9,  6'b011011, 0, "b2b_9a");
        xfer(12, 6'b110000, 0, "b2b_12");
        xfer(9,  6'b100010, 0, "b2b_9b");
        bus.in_valid = 1'b0;
        step();
        chk("drain_vld",  32'(bus.out_valid), 32'd0);
        chk("drain_code", 32'(bus.codeout), 32'b100010);

        // Backpressure
        do_reset();
        xfer(12, 6'b110000, 0, "bp_12");
        bus.out_ready = 1'b0;
        bus.datain    = 5'd9;
        #1;
        chk("bp_rdy", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_code", 32'(bus.codeout), 32'b110000);
            chk("bp_hold_vld",  32'(bus.out_valid), 32'd1);
            chk("bp_hold_rdy",  32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_rel_code", 32'(bus.codeout), 32'b100010);
        bus.in_valid = 1'b0;

        // Out of range keeps history
        do_reset();
        xfer(12, 6'b110000, 0, "ovf_12");
        xfer(16, 6'b000000, 1, "ovf_16");
        xfer(9,  6'b100010, 0, "ovf_9");
        bus.in_valid = 1'b0;

        // hist_clr on the following cycle
        do_reset();
        xfer(12, 6'b110000, 0, "clr_12");
        bus.in_valid = 1'b0;
        bus.hist_clr = 1'b1;
        step();
        bus.hist_clr = 1'b0;
        xfer(9, 6'b011011, 0, "clr_9");
        bus.in_valid = 1'b0;

        // hist_clr simultaneous with transfer: codeword uses old history
        do_reset();
        xfer(12, 6'b110000, 0, "sim_12");
        bus.hist_clr = 1'b1;
        xfer(9, 6'b100010, 0, "sim_9a");
        bus.hist_clr = 1'b0;
        xfer(9, 6'b011011, 0, "sim_9b");
        bus.in_valid = 1'b0;

        // Reset mid-hold
        do_reset();
        xfer(12, 6'b110000, 0, "mr_12");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk("mr_hold", 32'(bus.codeout), 32'b110000);
        rst_n = 1'b0;
        #1;
        chk("mr_code", 32'(bus.codeout), 32'd0);
        chk("mr_vld",  32'(bus.out_valid), 32'd0);
        chk("mr_ovf",  32'(bus.out_ovf), 32'd0);
        chk("mr_rdy",  32'(bus.in_ready), 32'd1);
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        xfer(9, 6'b011011, 0, "mr_9");
        bus.in_valid = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            int  v, am, nh;
            bit  rdy, xf, clr;
            v             = int'($urandom_range(0, 31));
            bus.datain    = 5'(v);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 7) == 0);
            bus.hist_clr  = clr;
            #1;
            rdy = !m_valid || bus.out_ready;
            chk("rnd_rdy", 32'(bus.in_ready), 32'(rdy));
            xf = bus.in_valid && rdy;
            nh = m_hist;
            if (xf) begin
                if (v >= CAP) begin
                    m_code = 0;
                    m_ovf  = 1;
                end else begin
                    m_code = enc(v, m_hist, am);
                    m_ovf  = 0;
                    nh     = am;
                end
                m_valid = 1;
            end else if (bus.out_ready) begin
                m_valid = 0;
            end
            if (clr) nh = 0;
            step();
            m_hist = nh;
            chk("rnd_code", 32'(bus.codeout), 32'(m_code));
            chk("rnd_vld",  32'(bus.out_valid), 32'(m_valid));
            chk("rnd_ovf",  32'(bus.out_ovf), 32'(m_ovf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tns_encoder_param.md
TNS_ENCODER_PARAM -- requirements
Module: tns_encoder_param

Interface
REQ-001 SHALL have parameter NG, default 11: number of 3-wire groups; codeword width CW = 3*NG.
REQ-002 SHALL have parameter DW, default 24: input data width in bits.
REQ-003 SHALL have parameter WEIGHTS, default full 11-group weight table, packed 3*NG fields of DW bits: field 3g+2 = A_g, field 3g+1 = B_g, field 3g = C_g, for g = NG-1..0; C_0 = 1.
REQ-004 SHALL have parameter CAP, default 2**DW: number of encodable values; inputs >= CAP are out of range.
REQ-005 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port datain, input, DW bits: unsigned value to encode.
REQ-008 SHALL have port in_valid, input, 1 bit: datain valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept datain.
REQ-010 SHALL have port hist_clr, input, 1 bit: synchronous clear of the per-group history bits.
REQ-011 SHALL have port codeout, output, CW bits: registered codeword.
REQ-012 SHALL have port out_valid, output, 1 bit: codeout valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts codeout.
REQ-014 SHALL have port out_ovf, output, 1 bit: registered flag, held codeword came from an out-of-range input.

Function
REQ-015 Encoding SHALL process groups MSB-first with running remainder r (starting at datain), DW-bit unsigned arithmetic; group g occupies codeout bits [3g+2:3g] as {a,b,c}.
REQ-016 Bit a_g SHALL be 0 if r < A_g, 1 if r >= A_g + C_g, else the history bit h_g; if a_g = 1 then r -= A_g.
REQ-017 Bit b_g SHALL be (r >= B_g); if 1 then r -= B_g.
REQ-018 For g > 0, bit c_g SHALL be (r >= C_g); if 1 then r -= C_g; c_0 SHALL equal bit 0 of the final remainder.
REQ-019 A transfer SHALL occur on any cycle with in_valid && in_ready; in_ready SHALL be !out_valid || out_ready (combinational; no in_valid→in_ready path).
REQ-020 On a transfer, codeout, out_ovf and out_valid = 1 SHALL be registered at the next rising edge; latency exactly 1 cycle.
REQ-021 When out_valid && out_ready and no transfer, out_valid SHALL fall to 0 next edge; codeout and out_ovf SHALL hold.
REQ-022 While out_valid && !out_ready, codeout, out_ovf, out_valid and history SHALL stay stable.
REQ-023 On an in-range transfer, each h_g SHALL load the a_g just encoded.
REQ-024 If datain >= CAP on a transfer, codeout SHALL be all zeros, out_ovf = 1, and history SHALL remain unchanged.
REQ-025 hist_clr = 1 SHALL clear all h_g at the next edge and SHALL take priority over a simultaneous history update; the codeword of a simultaneous transfer SHALL still use the pre-clear history.
REQ-026 Back-to-back transfers with out_ready = 1 SHALL sustain one codeword per cycle.

Reset
REQ-027 While rst_n = 0, asynchronously: codeout = 0, out_valid = 0, out_ovf = 0, all h_g = 0; in_ready = 1 results.
REQ-028 Reset asserted mid-stream SHALL discard the held codeword; the first transfer after release SHALL use all-zero history.

Verification
REQ-029 Test config: NG=2, DW=5, CAP=16, (A1,B1,C1,A0,B0,C0) = (8,4,3,2,1,1), out_ready = 1 unless stated.
REQ-030 Reset then idle → codeout = 6'b000000, out_valid = 0, out_ovf = 0, in_ready = 1.
REQ-031 After reset, datain 5 transferred → next cycle out_valid = 1, codeout = 6'b010010.
REQ-032 After reset, transfer 9, 12, 9 back-to-back → codeout 6'b011011, 6'b110000, 6'b100010 on consecutive cycles; 12 sets h_1 = 1, which changes the second 9's codeword.
REQ-033 Transfer 12, out_ready = 0 for 3 cycles, datain 9 with in_valid held → in_ready = 0, codeout holds 6'b110000; after out_ready = 1, codeout = 6'b100010.
REQ-034 Transfer 12, then 16, then 9 → 6'b110000; then 6'b000000 with out_ovf = 1; then 6'b100010 with out_ovf = 0 (history kept).
REQ-035 Transfer 12 with hist_clr pulsed the following cycle, then transfer 9 → 6'b011011; reset mid-hold → outputs 0 immediately.
